// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide execute unit.
//
// Contents:
//   ADDR_W_DEFAULT - default register address width (32 registers)
//   OP_*           - operation select codes driven on mul_div_unit.op
//   state_t        - control FSM state encoding (IDLE, CALC, DONE)
//
// OP_UMULH / OP_SMULH are always defined here so the code space is fixed.
// They only decode to real operations when MUL_DIV_MULH_EN is defined.

package mul_div_pkg;

  localparam int ADDR_W_DEFAULT = 5;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UDIV  = 3'b001;
  localparam logic [2:0] OP_SDIV  = 3'b010;
  localparam logic [2:0] OP_UMULH = 3'b100;
  localparam logic [2:0] OP_SMULH = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One radix-2 restoring-division step, purely combinational.
//
// Ports:
//   remainder_i    - partial remainder from the previous step (always < divisor)
//   dividendBit_i  - next dividend bit, MSB first
//   divisor_i      - divisor (non-zero whenever the result is used)
//   remainder_o    - partial remainder for the next step
//   quotientBit_o  - quotient bit produced by this step

module div_step #(
  parameter int n = 64
) (
  input  logic [n-1:0] remainder_i,
  input  logic         dividendBit_i,
  input  logic [n-1:0] divisor_i,
  output logic [n-1:0] remainder_o,
  output logic         quotientBit_o
);

  logic [n:0] shifted;
  logic [n:0] diff;

  // Shift the next dividend bit into the remainder and trial-subtract the
  // divisor. The remainder is always below the divisor, so the shifted value
  // is below twice the divisor: bit n of the difference is a clean borrow
  // flag, and a successful subtraction always fits back into n bits.
  always_comb begin
    shifted       = {remainder_i, dividendBit_i};
    diff          = shifted - {1'b0, divisor_i};
    quotientBit_o = ~diff[n];
    remainder_o   = quotientBit_o ? diff[n-1:0] : shifted[n-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle radix-2 integer multiply/divide execute unit.
//
// Sits downstream of the register bank: takes its two read-port values as
// operands and returns a result with write strobe and destination address
// that drive the bank's write port. One operation in flight, with a
// start/busy/done handshake toward the control unit.
//
// Ports:
//   clock          - system clock, rising edge
//   reset          - synchronous active-high reset
//   start          - request, accepted only when busy is low
//   op             - operation select (see mul_div_pkg OP_* codes)
//   operand_a      - first operand (bank output_data_1)
//   operand_b      - second operand (bank output_data_2)
//   dest_address   - destination register of the result
//   busy           - high whenever the FSM is not IDLE
//   done           - one-cycle completion pulse
//   write          - register bank write strobe, identical to done
//   write_address  - destination register latched for the completed operation
//   result         - result, held until the next completion
//
// Configuration macro:
//   MUL_DIV_MULH_EN - when defined, adds UMULH (op 100) and SMULH (op 101).
//                     When undefined those codes behave as reserved codes
//                     and the upper-half sign fixup is not built.

module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int n      = 64,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [n-1:0]      operand_a,
  input  logic [n-1:0]      operand_b,
  input  logic [ADDR_W-1:0] dest_address,
  output logic              busy,
  output logic              done,
  output logic              write,
  output logic [ADDR_W-1:0] write_address,
  output logic [n-1:0]      result
);

  localparam int              CNT_W = $clog2(n);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(n - 1);

  state_t              state_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [n-1:0]        hi_q;
  logic [n-1:0]        lo_q;
  logic [n-1:0]        mcand_q;
  logic                neg_q;
  logic [CNT_W-1:0]    count_q;
  logic                done_q;
  logic [n-1:0]        result_q;
  logic [ADDR_W-1:0]   waddr_q;

  logic [n-1:0]        hi_d;
  logic [n-1:0]        lo_d;
  logic [n-1:0]        result_d;
  logic [n:0]          mulSum;
  logic [n-1:0]        remNext;
  logic                quotBit;

  logic                signedOp;
  logic                divOp;
  logic                divByZero;
  logic [n-1:0]        aLoad;
  logic [n-1:0]        bLoad;

`ifdef MUL_DIV_MULH_EN
  logic [n-1:0]        smulhHigh;
`endif

  div_step #(
    .n(n)
  ) u_div_step (
    .remainder_i   (hi_q),
    .dividendBit_i (lo_q[n-1]),
    .divisor_i     (mcand_q),
    .remainder_o   (remNext),
    .quotientBit_o (quotBit)
  );

  // Operand preparation at accept time. Signed operations work on
  // magnitudes with the result sign kept aside in neg_q. Negating the most
  // negative value yields the same bit pattern, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  // Operand a goes to the shifting register (multiplier / dividend) and b
  // to the fixed register (multiplicand / divisor); the product is
  // symmetric, so one loading rule serves both families.
  always_comb begin
    signedOp = (op == OP_SDIV);
`ifdef MUL_DIV_MULH_EN
    signedOp = signedOp || (op == OP_SMULH);
`endif
    divOp     = (op == OP_UDIV) || (op == OP_SDIV);
    divByZero = divOp && (operand_b == '0);
    aLoad     = (signedOp && operand_a[n-1]) ? -operand_a : operand_a;
    bLoad     = (signedOp && operand_b[n-1]) ? -operand_b : operand_b;
  end

  // One datapath iteration. Multiply is shift-add over the 2n-bit register
  // {hi_q, lo_q}: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole thing right including the
  // carry. Divide shifts dividend bits out of lo_q into the remainder in
  // hi_q via div_step and shifts quotient bits into the bottom of lo_q.
  // Reserved codes just hold so they still take the full latency.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    mulSum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(n+1){1'b0}});
    case (op_q)
      OP_MUL: begin
        hi_d = mulSum[n:1];
        lo_d = {mulSum[0], lo_q[n-1:1]};
      end
`ifdef MUL_DIV_MULH_EN
      OP_UMULH, OP_SMULH: begin
        hi_d = mulSum[n:1];
        lo_d = {mulSum[0], lo_q[n-1:1]};
      end
`endif
      OP_UDIV, OP_SDIV: begin
        hi_d = remNext;
        lo_d = {lo_q[n-2:0], quotBit};
      end
      default: begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    endcase
  end

`ifdef MUL_DIV_MULH_EN
  // High half of the 2n-bit two's complement negate of {hi_d, lo_d}: the
  // +1 of the low half only carries into the high half when the low half
  // is all zeros.
  always_comb begin
    smulhHigh = hi_d;
    if (neg_q) begin
      smulhHigh = ~hi_d + n'(lo_d == '0);
    end
  end
`endif

  // Result selection from the values produced by the final iteration.
  always_comb begin
    result_d = '0;
    case (op_q)
      OP_MUL:  result_d = lo_d;
      OP_UDIV: result_d = lo_d;
      OP_SDIV: result_d = neg_q ? -lo_d : lo_d;
`ifdef MUL_DIV_MULH_EN
      OP_UMULH: result_d = hi_d;
      OP_SMULH: result_d = smulhHigh;
`endif
      default: result_d = '0;
    endcase
  end

  // Control FSM with all outputs registered. IDLE accepts a request and
  // latches everything the operation needs; a divide by zero skips CALC and
  // completes with result 0. CALC runs exactly n iterations and publishes
  // result and write address as it enters DONE. DONE raises done/write for
  // the following cycle and returns to IDLE. Requests seen outside IDLE are
  // dropped. Reset aborts whatever is in flight without a completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dest_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            dest_q  <= dest_address;
            hi_q    <= '0;
            lo_q    <= aLoad;
            mcand_q <= bLoad;
            neg_q   <= signedOp && (operand_a[n-1] ^ operand_b[n-1]);
            count_q <= '0;
            if (divByZero) begin
              state_q  <= DONE;
              result_q <= '0;
              waddr_q  <= dest_address;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST) begin
            state_q  <= DONE;
            result_q <= result_d;
            waddr_q  <= dest_q;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign write         = done_q;
  assign write_address = waddr_q;
  assign result        = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (n = 64, ADDR_W = 5).
// Vector table plus random MUL/UDIV run through a scoreboard queue; hand
// sequences cover ignored starts, divide-by-zero back-to-back issue and
// reset abort. Honours MUL_DIV_MULH_EN for the upper-product codes.

module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int N  = 64;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [N-1:0]  operandA;
  logic [N-1:0]  operandB;
  logic [AW-1:0] destAddress;
  logic          busy;
  logic          done;
  logic          write;
  logic [AW-1:0] writeAddress;
  logic [N-1:0]  result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [AW-1:0] dest;
    logic [N-1:0]  expResult;
    bit            fast;
  } vec_t;

  typedef struct {
    logic [N-1:0]  result;
    logic [AW-1:0] addr;
    bit            fast;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];

  mul_div_unit #(
    .n(N),
    .ADDR_W(AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .operand_a     (operandA),
    .operand_b     (operandB),
    .dest_address  (destAddress),
    .busy          (busy),
    .done          (done),
    .write         (write),
    .write_address (writeAddress),
    .result        (result)
  );

  always #5 clock = ~clock;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Called #1 after a clock edge; start is high for exactly the next edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [AW-1:0] d);
    op          = o;
    operandA    = a;
    operandB    = b;
    destAddress = d;
    start       = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares.
  task automatic waitResult(input string name, output int latency);
    int   k;
    bit   seen;
    exp_t e;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(posedge clock);
      #1;
      k++;
      if (done === 1'b1) seen = 1'b1;
    end
    latency = k;
    checkOutput({name, " done seen"}, 64'(seen), 64'd1);
    if (expQ.size() == 0) begin
      checkOutput({name, " scoreboard entry"}, 64'd0, 64'd1);
    end else begin
      e = expQ.pop_front();
      if (seen) begin
        checkOutput({name, " result"}, result, e.result);
        checkOutput({name, " write_address"}, 64'(writeAddress), 64'(e.addr));
        checkOutput({name, " write"}, 64'(write), 64'd1);
        if (e.fast)
          checkOutput({name, " fast latency 1..2"}, 64'(k >= 1 && k <= 2), 64'd1);
        else
          checkOutput({name, " latency"}, 64'(k), 64'd65);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   pulses;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    vecs.push_back('{OP_MUL,  64'd7, 64'd6, 5'd3, 64'd42, 1'b0});
    vecs.push_back('{OP_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{OP_MUL,  64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd2, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0});
    vecs.push_back('{OP_UDIV, 64'd100, 64'd7, 5'd5, 64'd14, 1'b0});
    vecs.push_back('{OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{OP_UDIV, 64'd3, 64'd10, 5'd7, 64'd0, 1'b0});
    vecs.push_back('{OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    vecs.push_back('{OP_SDIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    vecs.push_back('{OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 5'd10, 64'd3, 1'b0});
    vecs.push_back('{OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'h8000_0000_0000_0000, 1'b0});
    vecs.push_back('{OP_UDIV, 64'd5, 64'd0, 5'd12, 64'd0, 1'b1});
    vecs.push_back('{OP_SDIV, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd13, 64'd0, 1'b1});
    vecs.push_back('{3'b011,  64'd9, 64'd9, 5'd14, 64'd0, 1'b0});
    vecs.push_back('{3'b111,  64'd9, 64'd9, 5'd15, 64'd0, 1'b0});
    vecs.push_back('{3'b110,  64'd9, 64'd9, 5'd16, 64'd0, 1'b0});
`ifdef MUL_DIV_MULH_EN
    vecs.push_back('{OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd17, 64'd1, 1'b0});
    vecs.push_back('{OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd18, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{OP_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd19, 64'h4000_0000_0000_0000, 1'b0});
`else
    vecs.push_back('{OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd17, 64'd0, 1'b0});
    vecs.push_back('{OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd18, 64'd0, 1'b0});
`endif

    reset       = 1'b1;
    start       = 1'b0;
    op          = '0;
    operandA    = '0;
    operandB    = '0;
    destAddress = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset write", 64'(write), 64'd0);
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset write_address", 64'(writeAddress), 64'd0);

    // MUL 7*6 with starts at edges 10 and 40 that must be ignored
    $display("[TB] sequence: MUL with ignored starts");
    applyStimulus(OP_MUL, 64'd7, 64'd6, 5'd3);
    checkOutput("seqA busy after start", 64'(busy), 64'd1);
    pulses = 0;
    for (int k = 1; k <= 66; k++) begin
      if (k == 10 || k == 40) begin
        op          = OP_MUL;
        operandA    = 64'd9;
        operandB    = 64'd9;
        destAddress = 5'd9;
        start       = 1'b1;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      if (k < 65 && done === 1'b1) pulses++;
      if (k == 64) begin
        checkOutput("seqA busy before done", 64'(busy), 64'd1);
        checkOutput("seqA done not yet", 64'(done), 64'd0);
      end
      if (k == 65) begin
        checkOutput("seqA done", 64'(done), 64'd1);
        checkOutput("seqA write", 64'(write), 64'd1);
        checkOutput("seqA result", result, 64'd42);
        checkOutput("seqA write_address", 64'(writeAddress), 64'd3);
      end
      if (k == 66) begin
        checkOutput("seqA done pulse width", 64'(done), 64'd0);
        checkOutput("seqA busy dropped", 64'(busy), 64'd0);
      end
    end
    checkOutput("seqA no early done", 64'(pulses), 64'd0);

    $display("[TB] sequence: vector table");
    foreach (vecs[i]) begin
      expQ.push_back('{vecs[i].expResult, vecs[i].dest, vecs[i].fast});
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
      waitResult($sformatf("vec%0d", i), lat);
    end

    $display("[TB] sequence: random MUL/UDIV");
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      expQ.push_back('{ra * rb, 5'(i), 1'b0});
      applyStimulus(OP_MUL, ra, rb, 5'(i));
      waitResult($sformatf("rmul%0d", i), lat);
      rb = 64'($urandom_range(1, 1000));
      expQ.push_back('{ra / rb, 5'(i + 20), 1'b0});
      applyStimulus(OP_UDIV, ra, rb, 5'(i + 20));
      waitResult($sformatf("rdiv%0d", i), lat);
    end

    // Divide by zero at edge 0, next request at edge 3 must be accepted
    $display("[TB] sequence: divide by zero then back-to-back start");
    expQ.push_back('{64'd0, 5'd4, 1'b1});
    applyStimulus(OP_UDIV, 64'd5, 64'd0, 5'd4);
    waitResult("seqB udiv by zero", lat);
    while (lat < 2) begin
      @(posedge clock);
      #1;
      lat++;
    end
    expQ.push_back('{64'd12, 5'd8, 1'b0});
    applyStimulus(OP_MUL, 64'd3, 64'd4, 5'd8);
    checkOutput("seqB start at edge 3 accepted", 64'(busy), 64'd1);
    waitResult("seqB mul after div0", lat);

    // Reset at edge 20 of a MUL aborts it silently
    $display("[TB] sequence: reset mid-operation");
    applyStimulus(OP_MUL, 64'd7, 64'd6, 5'd6);
    for (int k = 1; k <= 19; k++) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("seqC busy after reset", 64'(busy), 64'd0);
    checkOutput("seqC result after reset", result, 64'd0);
    checkOutput("seqC write_address after reset", 64'(writeAddress), 64'd0);
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      if (done === 1'b1 || write === 1'b1) pulses++;
      @(posedge clock);
      #1;
    end
    checkOutput("seqC no done after abort", 64'(pulses), 64'd0);
    expQ.push_back('{64'd12, 5'd7, 1'b0});
    applyStimulus(OP_MUL, 64'd3, 64'd4, 5'd7);
    waitResult("seqC mul after reset", lat);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
